// File: rtl/rf_wb_arbiter.sv
// Three-requester round-robin write-back arbiter feeding one register-file write port,
// with a pending-write scoreboard. Define RF_WB_ARBITER_BYPASS_EN to add read-bypass ports.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [3*AW-1:0]   req_addr,
    input  logic [3*DW-1:0]   req_data,
    output logic [2:0]        req_ready,
    input  logic              hold,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
`ifdef RF_WB_ARBITER_BYPASS_EN
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DW-1:0]     byp_data1,
    output logic [DW-1:0]     byp_data2,
`endif
    output logic              rf_we,
    output logic [AW-1:0]     rf_addr,
    output logic [DW-1:0]     rf_wdata,
    output logic [2**AW-1:0]  pending
);
    localparam int NREG = 2**AW;

    logic [1:0]    ptr_reg;
    logic [2:0]    grant;
    logic [1:0]    grant_idx;
    logic [2:0]    scan;
    logic          found;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Search ptr, ptr+1, ptr+2 (mod 3); the first valid requester wins.
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        found     = 1'b0;
        scan      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            scan = {1'b0, ptr_reg} + 3'(k);
            if (scan >= 3'd3) begin
                scan = scan - 3'd3;
            end
            if (!found && req_valid[scan[1:0]]) begin
                found            = 1'b1;
                grant_idx        = scan[1:0];
                grant[scan[1:0]] = 1'b1;
            end
        end
        if (rst || hold) begin
            grant = 3'b000;
            found = 1'b0;
        end
    end

    assign req_ready = grant;
    assign sel_addr  = req_addr[grant_idx*AW +: AW];
    assign sel_data  = req_data[grant_idx*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg  <= 2'd0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= found;
            if (found) begin
                ptr_reg  <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
                rf_addr  <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // Set has priority over clear so a new reservation survives a same-cycle write-back.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            assign set_bit = rsv_valid && (rsv_addr == AW'(gi));
            assign clr_bit = rf_we && (rf_addr == AW'(gi));
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending[gi] <= 1'b0;
                end else if (set_bit) begin
                    pending[gi] <= 1'b1;
                end else if (clr_bit) begin
                    pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef RF_WB_ARBITER_BYPASS_EN
    assign byp_hit1  = rf_we && (rf_addr == rd_addr1);
    assign byp_hit2  = rf_we && (rf_addr == rd_addr2);
    assign byp_data1 = rf_wdata;
    assign byp_data2 = rf_wdata;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter: a reference model predicts grants and
// pending bits, and a queue of expected writes is drained by an independent monitor.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req_valid = '0;
    logic [3*AW-1:0] req_addr = '0;
    logic [3*DW-1:0] req_data = '0;
    logic [2:0]      req_ready;
    logic            hold = 1'b0;
    logic            rsv_valid = 1'b0;
    logic [AW-1:0]   rsv_addr = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_wdata;
    logic [7:0]      pending;
`ifdef RF_WB_ARBITER_BYPASS_EN
    logic [AW-1:0]   rd_addr1 = '0;
    logic [AW-1:0]   rd_addr2 = '0;
    logic            byp_hit1, byp_hit2;
    logic [DW-1:0]   byp_data1, byp_data2;
`endif

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .hold(hold),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
`ifdef RF_WB_ARBITER_BYPASS_EN
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          edge_cnt = 0;
    int          m_ptr = 0;
    logic [7:0]  m_pend = '0;
    logic        m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int          last_grant = -1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every presented write must be the oldest expected one, on its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'(rf_addr), 64'hFFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    $display("WR cyc=%0d addr=%0d data=%08h", edge_cnt, rf_addr, rf_wdata);
                    chk("wr_addr", 64'(rf_addr), 64'(e.addr));
                    chk("wr_data", 64'(rf_wdata), 64'(e.data));
                    chk("wr_latency", 64'(edge_cnt), 64'(e.due));
`ifdef RF_WB_ARBITER_BYPASS_EN
                    chk("byp_hit1", 64'(byp_hit1), 64'(e.addr == rd_addr1));
                    chk("byp_hit2", 64'(byp_hit2), 64'(e.addr == rd_addr2));
                    chk("byp_data1", 64'(byp_data1), 64'(e.data));
                    chk("byp_data2", 64'(byp_data2), 64'(e.data));
`endif
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                chk("wr_missing", 64'(rf_we), 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; the model predicts this cycle's grant and the state after the edge.
    task automatic step(input logic [2:0] v, input logic h, input logic rv,
                        input logic [AW-1:0] ra, input logic [3*AW-1:0] a,
                        input logic [3*DW-1:0] d);
        int g;
        @(posedge clk);
        #1;
        chk("pending", 64'(pending), 64'(m_pend));
        req_valid = v; hold = h; rsv_valid = rv; rsv_addr = ra;
        req_addr = a; req_data = d;
`ifdef RF_WB_ARBITER_BYPASS_EN
        rd_addr1 = AW'($urandom_range(0, 7));
        rd_addr2 = AW'($urandom_range(0, 7));
`endif
        #1;
        g = -1;
        if (!h) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        last_grant = g;
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (m_we) m_pend[m_addr] = 1'b0;
        if (rv) m_pend[ra] = 1'b1;
        if (g >= 0) begin
            wr_t e;
            e.addr = a[g*AW +: AW];
            e.data = d[g*DW +: DW];
            e.due  = edge_cnt + 1;
            exp_q.push_back(e);
            m_ptr  = (g + 1) % 3;
            m_we   = 1'b1;
            m_addr = e.addr;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exp_q.delete();
        req_valid = 3'b111; rsv_valid = 1'b1; rsv_addr = AW'($urandom_range(0, 7)); hold = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_pending", 64'(pending), 64'd0);
        chk("rst_hold_rf_addr", 64'({rf_addr, rf_wdata}), 64'd0);
        m_ptr = 0; m_pend = '0; m_we = 1'b0;
        @(negedge clk);
        rst = 1'b0; req_valid = '0; rsv_valid = 1'b0;
    endtask

    function automatic logic [3*AW-1:0] rnd_a();
        return (3*AW)'($urandom);
    endfunction

    function automatic logic [3*DW-1:0] rnd_d();
        return {$urandom, $urandom, $urandom};
    endfunction

    int rr_exp[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        reset_dut();

        // Round-robin under continuous requests.
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 1'b0, 1'b0, '0, rnd_a(), rnd_d());
            chk("rr_grant", 64'(last_grant), 64'(rr_exp[i]));
        end

        // Hold suppresses grants, then requester 1 is served.
        for (int i = 0; i < 3; i++) begin
            step(3'b010, 1'b1, 1'b0, '0, rnd_a(), rnd_d());
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        step(3'b010, 1'b0, 1'b0, '0, rnd_a(), rnd_d());
        chk("hold_release_grant", 64'(last_grant), 64'd1);

        // Reservation of r5 cleared by requester 2's write-back.
        reset_dut();
        step(3'b000, 1'b0, 1'b1, 3'd5, '0, '0);
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        step(3'b100, 1'b0, 1'b0, '0, {3'd5, 3'd0, 3'd0}, {32'hDEADBEEF, 64'd0});
        chk("sb_pending5_c2", 64'(pending[5]), 64'd1);
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        chk("sb_pending5_c3", 64'(pending[5]), 64'd1);
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        chk("sb_pending5_c4", 64'(pending[5]), 64'd0);

        // Write-back to r4 in the same cycle as a new reservation of r4.
        step(3'b001, 1'b0, 1'b1, 3'd4, {3'd0, 3'd0, 3'd4}, rnd_d());
        step(3'b000, 1'b0, 1'b1, 3'd4, '0, '0);
        chk("collide_rf_we", 64'({rf_we, rf_addr}), 64'({1'b1, 3'd4}));
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        chk("collide_pending4", 64'(pending[4]), 64'd1);

        // Reset while a write is in flight discards it immediately.
        step(3'b010, 1'b0, 1'b1, 3'd2, rnd_a(), rnd_d());
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("inflight_rf_we", 64'(rf_we), 64'd1);
        reset_dut();
        step(3'b111, 1'b0, 1'b0, '0, rnd_a(), rnd_d());
        chk("post_rst_grant", 64'(last_grant), 64'd0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                 AW'($urandom), rnd_a(), rnd_d());
        end
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        step(3'b000, 1'b0, 1'b0, '0, '0, '0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning write-data width.
REQ-002 SHALL have parameter AW, default 3, meaning register-address width (2**AW registers).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  3  per-requester write request; bit i = requester i.
REQ-006 SHALL have port req_addr  input  3*AW  destination register addresses; requester i at bits [i*AW +: AW].
REQ-007 SHALL have port req_data  input  3*DW  write data; requester i at bits [i*DW +: DW].
REQ-008 SHALL have port req_ready  output  3  one-hot-or-zero grant; a transfer occurs when req_valid[i] && req_ready[i].
REQ-009 SHALL have port hold  input  1  when 1, no grants are issued.
REQ-010 SHALL have port rsv_valid  input  1  reserve a register as pending-write.
REQ-011 SHALL have port rsv_addr  input  AW  register to reserve.
REQ-012 SHALL have port rf_we  output  1  register-file write enable.
REQ-013 SHALL have port rf_addr  output  AW  register-file write address.
REQ-014 SHALL have port rf_wdata  output  DW  register-file write data.
REQ-015 SHALL have port pending  output  2**AW  bit r = register r has an outstanding reservation.

Function
REQ-016 SHALL compute req_ready combinationally from req_valid, hold and the priority pointer; no dependency on req_ready-to-valid loops.
REQ-017 SHALL grant at most one requester per cycle: the first valid requester starting at pointer ptr, searching ptr, ptr+1, ptr+2 mod 3.
REQ-018 SHALL drive req_ready = 0 in any cycle with hold = 1 or req_valid = 0.
REQ-019 SHALL, after a grant to requester i, set ptr to (i+1) mod 3; ptr unchanged when no grant.
REQ-020 SHALL register the granted request: grant in cycle N yields rf_we=1, rf_addr, rf_wdata of that requester in cycle N+1 (latency 1).
REQ-021 SHALL drive rf_we = 0 in cycle N+1 when no grant in cycle N; rf_addr/rf_wdata hold previous values.
REQ-022 SHALL sustain one write per cycle under continuous requests (back-to-back grants, no bubbles).
REQ-023 SHALL set pending[rsv_addr] at the clock edge when rsv_valid = 1.
REQ-024 SHALL clear pending[rf_addr] at the clock edge ending a cycle with rf_we = 1.
REQ-025 SHALL, on simultaneous set and clear of the same register, leave the bit set (reservation wins).
REQ-026 SHALL leave pending unchanged for writes to unreserved registers; a clear of a 0 bit is a no-op.
REQ-027 SHALL not reorder or drop granted writes; two grants to the same address issue in grant order.

Reset
REQ-028 SHALL, while rst = 1, force ptr = 0, rf_we = 0, rf_addr = 0, rf_wdata = 0, pending = 0.
REQ-029 SHALL drive req_ready = 0 while rst = 1.
REQ-030 SHALL discard a write registered but not yet issued when rst asserts mid-operation; rf_we = 0 immediately on rst.
REQ-031 SHALL grant normally from the first rising edge after rst deasserts, requester 0 highest priority.

Configuration
REQ-032 SHALL support macro RF_WB_ARBITER_BYPASS_EN.
REQ-033 With RF_WB_ARBITER_BYPASS_EN defined, SHALL add inputs rd_addr1, rd_addr2 (AW) and outputs byp_hit1, byp_hit2 (1), byp_data1, byp_data2 (DW): byp_hitk = rf_we && rf_addr == rd_addrk, byp_datak = rf_wdata, combinational.
REQ-034 Without RF_WB_ARBITER_BYPASS_EN, SHALL omit those ports; all other behaviour identical.

Verification
REQ-035 Reset: assert rst with req_valid=3'b111, rsv_valid=1 -> req_ready=0, rf_we=0, pending=0; after release, first grant to requester 0.
REQ-036 Round-robin: req_valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; rf_we=1 from cycle 2 with matching rf_addr/rf_wdata.
REQ-037 Hold: req_valid=3'b010, hold=1 for 3 cycles then 0 -> req_ready=0 during hold, grant to 1 on first cycle after, rf_we one cycle later.
REQ-038 Scoreboard: rsv 5 in cycle 0, requester 2 writes addr 5 data 0xDEADBEEF in cycle 2 -> pending[5]=1 cycles 1-3, rf_we cycle 3, pending[5]=0 cycle 4.
REQ-039 Collision: rf_we=1 rf_addr=4 while rsv_valid=1 rsv_addr=4 -> pending[4] remains 1.
REQ-040 Bypass (macro defined): rf_we=1 rf_addr=3 rf_wdata=0x12345678, rd_addr1=3, rd_addr2=6 -> byp_hit1=1, byp_data1=0x12345678, byp_hit2=0.
